fire6_squeeze_ofm_buffer: RTL and testbench

FIRE6_SQUEEZE_OFM_BUFFER -- requirements
Module: fire6_squeeze_ofm_buffer

---
 rtl/fire6_squeeze_ofm_buffer.sv | 162 ++++++++++++++++
 tb/tb_fire6_squeeze_ofm_buffer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fire6_squeeze_ofm_buffer.sv
// Squeeze-stage output feature-map buffer.
//
// Captures one CH-word sample from the squeeze stage, serialises it into a
// WOUT*WOUT*CH word RAM one channel per cycle, and once every pixel of the
// layer is stored raises ram_feedback, pulses expand_start_o and serves reads
// for the expand stage.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   sample_i        one-cycle strobe, ofm_i valid in that cycle
//   ofm_i           per-channel squeeze results [0:CH-1]
//   rd_en_i         read request (honoured only once the layer is complete)
//   rd_addr_i       read address = pixel*CH + channel
//   rd_data_o       read data, one cycle after rd_en_i
//   rd_valid_o      rd_data_o valid
//   ram_feedback    level, high once the full layer is stored
//   expand_start_o  one-cycle pulse when the layer completes
//   busy_o          high while serialising a captured sample
//   overrun_o       sticky, a sample arrived while busy
//   pixel_count_o   number of pixels fully written
module fire6_squeeze_ofm_buffer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CH    = 64,
    parameter int unsigned WOUT  = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                sample_i,
    input  logic [WIDTH-1:0]                    ofm_i [0:CH-1],
    input  logic                                rd_en_i,
    input  logic [$clog2(WOUT*WOUT*CH)-1:0]     rd_addr_i,
    output logic [WIDTH-1:0]                    rd_data_o,
    output logic                                rd_valid_o,
    output logic                                ram_feedback,
    output logic                                expand_start_o,
    output logic                                busy_o,
    output logic                                overrun_o,
    output logic [$clog2(WOUT*WOUT):0]          pixel_count_o
);

    localparam int unsigned NPix  = WOUT * WOUT;
    localparam int unsigned Depth = NPix * CH;
    localparam int unsigned AW    = $clog2(Depth);
    localparam int unsigned PW    = $clog2(NPix) + 1;
    localparam int unsigned CW    = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       ch_q, ch_d;
    logic [PW-1:0]       pix_q, pix_d;
    logic                overrun_q, overrun_d;
    logic                feedback_q, feedback_d;
    logic                start_q, start_d;
    logic                rd_valid_q;
    logic [WIDTH-1:0]    rd_data_q;
    logic [WIDTH-1:0]    hold_q [0:CH-1];
    logic [WIDTH-1:0]    mem_q [Depth];
    logic                capture;
    logic                we;
    logic                rd_hit;
    logic [AW-1:0]       waddr;

    assign waddr  = AW'(pix_q) * AW'(CH) + AW'(ch_q);
    assign rd_hit = rd_en_i && (state_q == StDone);

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        pix_d      = pix_q;
        overrun_d  = overrun_q;
        feedback_d = feedback_q;
        start_d    = 1'b0;
        capture    = 1'b0;
        we         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sample_i) begin
                    capture = 1'b1;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                we = 1'b1;
                // A strobe during any write cycle, including the last, is lost.
                if (sample_i) begin
                    overrun_d = 1'b1;
                end
                if (ch_q == CW'(CH - 1)) begin
                    ch_d  = '0;
                    pix_d = pix_q + 1'b1;
                    if (pix_q == PW'(NPix - 1)) begin
                        state_d    = StDone;
                        start_d    = 1'b1;
                        feedback_d = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
            StDone: begin
                // Terminal until reset; strobes are ignored here.
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Reset is used directly: the first edge with rst low already advances
    // the FSM, so a strobe at that edge is captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            ch_q       <= '0;
            pix_q      <= '0;
            overrun_q  <= 1'b0;
            feedback_q <= 1'b0;
            start_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            pix_q      <= pix_d;
            overrun_q  <= overrun_d;
            feedback_q <= feedback_d;
            start_q    <= start_d;
            rd_valid_q <= rd_hit;
            if (rd_hit) begin
                rd_data_q <= (32'(rd_addr_i) < Depth) ? mem_q[rd_addr_i] : '0;
            end
        end
    end

    // Holding register is discarded on reset so an abandoned pixel leaves no trace.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '{default: '0};
        end else if (capture) begin
            hold_q <= ofm_i;
        end
    end

    // RAM has no reset: contents survive rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= hold_q[ch_q];
        end
    end

    assign rd_data_o      = rd_data_q;
    assign rd_valid_o     = rd_valid_q;
    assign ram_feedback   = feedback_q;
    assign expand_start_o = start_q;
    assign busy_o         = (state_q == StWrite);
    assign overrun_o      = overrun_q;
    assign pixel_count_o  = pix_q;

endmodule

// File: tb/tb_fire6_squeeze_ofm_buffer.sv
module tb_fire6_squeeze_ofm_buffer;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned CH    = 6;
    localparam int unsigned WOUT  = 3;
    localparam int unsigned NPIX  = WOUT * WOUT;
    localparam int unsigned DEPTH = NPIX * CH;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PW    = $clog2(NPIX) + 1;

    logic             clk;
    logic             rst;
    logic             sample_i;
    logic [WIDTH-1:0] ofm [0:CH-1];
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             ram_feedback;
    logic             expand_start;
    logic             busy;
    logic             overrun;
    logic [PW-1:0]    pixel_count;

    fire6_squeeze_ofm_buffer #(
        .WIDTH (WIDTH),
        .CH    (CH),
        .WOUT  (WOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sample_i       (sample_i),
        .ofm_i          (ofm),
        .rd_en_i        (rd_en),
        .rd_addr_i      (rd_addr),
        .rd_data_o      (rd_data),
        .rd_valid_o     (rd_valid),
        .ram_feedback   (ram_feedback),
        .expand_start_o (expand_start),
        .busy_o         (busy),
        .overrun_o      (overrun),
        .pixel_count_o  (pixel_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: the layer as a plain array plus the acceptance rules.
    logic [WIDTH-1:0] ref_mem [DEPTH];
    int               m_pix  = 0;
    bit               m_done = 1'b0;
    bit               m_ovr  = 1'b0;
    longint           m_last = -100;

    int               n_checks = 0;
    int               n_pass   = 0;
    logic [WIDTH-1:0] exp_q [$];
    int               addr_q [$];
    int               exp_pulses = 0;
    int               reads_seen = 0;
    logic             fb_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic randomize_ofm();
        for (int c = 0; c < CH; c++) ofm[c] = WIDTH'($urandom);
    endtask

    // Strobe sample_i across exactly one edge and update the model.
    task automatic issue_sample();
        longint e;
        tick();
        sample_i = 1'b1;
        @(posedge clk);
        #1;
        sample_i = 1'b0;
        e = longint'(cyc);
        if (e - m_last < longint'(CH + 1)) begin
            m_ovr = 1'b1;
        end else if (!m_done) begin
            for (int c = 0; c < CH; c++) ref_mem[m_pix * CH + c] = ofm[c];
            m_pix++;
            m_last = e;
            if (m_pix == NPIX) m_done = 1'b1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pixel_count"}, pixel_count, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_ram_feedback"}, ram_feedback, 0);
        check({tag, "_expand_start"}, expand_start, 0);
        check({tag, "_rd_valid"}, rd_valid, 0);
        check({tag, "_rd_data"}, rd_data, 0);
    endtask

    // Read-data monitor: pops the scoreboard whenever the DUT presents data.
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            reads_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_rd_valid", rd_valid, 0);
            end else begin
                check($sformatf("rd_data[%0d]", addr_q.pop_front()), rd_data, exp_q.pop_front());
            end
        end
    end

    // Completion monitor: expand_start must coincide with ram_feedback rising.
    always @(negedge clk) begin
        if (!rst && expand_start) begin
            exp_pulses++;
            check("expand_start_with_feedback", ram_feedback, 1);
            check("feedback_low_before_start", fb_prev, 0);
        end
        fb_prev = ram_feedback;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1);
    end

    initial begin
        int bc;
        int sp;
        rst      = 1'b1;
        sample_i = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        for (int c = 0; c < CH; c++) ofm[c] = '0;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Pixel 0: known pattern, busy for exactly CH cycles after capture.
        idle(8);
        for (int c = 0; c < CH; c++) ofm[c] = WIDTH'(c + 'h100);
        issue_sample();
        bc = 0;
        for (int i = 0; i < int'(CH); i++) begin
            @(negedge clk);
            bc += int'(busy);
        end
        check("busy_cycles", bc, CH);
        @(negedge clk);
        check("busy_after_write", busy, 0);
        check("pixel_count_first", pixel_count, 1);

        // Pixels 1 and 2 exactly CH+1 cycles apart: both accepted.
        randomize_ofm();
        issue_sample();
        idle(CH - 1);
        randomize_ofm();
        issue_sample();
        idle(CH + 1);
        check("overrun_min_spacing", overrun, m_ovr);
        check("pixel_count_min_spacing", pixel_count, m_pix);

        // Strobes 3 cycles and CH cycles after a capture are both dropped.
        randomize_ofm();
        issue_sample();
        idle(1);
        randomize_ofm();
        issue_sample();
        idle(CH - 5);
        randomize_ofm();
        issue_sample();
        idle(CH + 1);
        check("overrun_set", overrun, m_ovr);
        check("pixel_count_after_drop", pixel_count, m_pix);

        // Reads before the layer is complete are ignored.
        rd_en = 1'b1;
        rd_addr = '0;
        tick();
        rd_en = 1'b0;
        @(negedge clk);
        check("early_read_valid", rd_valid, 0);
        check("early_read_data_held", rd_data, 0);

        // Reset in the middle of a pixel: outputs clear asynchronously.
        randomize_ofm();
        issue_sample();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("midwrite_reset");
        m_pix  = 0;
        m_ovr  = 1'b0;
        m_done = 1'b0;
        m_last = -100;
        tick();
        tick();
        rst = 1'b0;

        // Fill the whole layer with random data and legal random spacing.
        for (int p = 0; p < int'(NPIX); p++) begin
            idle($urandom_range(CH - 1, CH + 2));
            randomize_ofm();
            issue_sample();
            if (p == 0) begin
                idle(CH);
                check("pixel_count_after_reset", pixel_count, 1);
            end
        end
        idle(CH + 2);
        check("pixel_count_full", pixel_count, m_pix);
        check("ram_feedback_full", ram_feedback, 1);
        check("expand_start_pulses", exp_pulses, 1);
        check("overrun_after_fill", overrun, m_ovr);

        // A strobe in the terminal state changes nothing.
        randomize_ofm();
        issue_sample();
        idle(CH + 2);
        check("done_overrun", overrun, m_ovr);
        check("done_pixel_count", pixel_count, NPIX);
        check("done_busy", busy, 0);
        check("done_feedback_held", ram_feedback, 1);
        check("done_single_pulse", exp_pulses, 1);

        // Read back every word plus out-of-range addresses.
        for (int a = 0; a < int'(DEPTH) + 3; a++) begin
            sp = (a < int'(DEPTH)) ? a : ((a == int'(DEPTH)) ? int'(DEPTH) : (a == int'(DEPTH) + 1 ? 60 : 63));
            rd_addr = AW'(sp);
            rd_en = 1'b1;
            addr_q.push_back(sp);
            exp_q.push_back((sp < int'(DEPTH)) ? ref_mem[sp] : '0);
            tick();
            if ($urandom_range(0, 2) == 0) begin
                rd_en = 1'b0;
                tick();
            end
        end
        rd_en = 1'b0;
        idle(3);
        check("reads_seen", reads_seen, DEPTH + 3);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
